// File: rtl/bus_pkg.sv
// Definitions shared by the memory-mapped bus slaves and the CPU benches that drive them.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        DONE  = 2'd2
    } bus_state_e;

    localparam logic [31:0] BUS_BASE_ADDR = 32'hBFC00000;
    localparam int          BUS_DATA_W    = 32;
    localparam int          BUS_LANES     = BUS_DATA_W / 8;

endpackage

// File: rtl/byte_lane_ram.sv
// Word storage built from four byte-wide arrays with per-lane write enables,
// a full-word preload port and a registered (synchronous) read port.
module byte_lane_ram
    import bus_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic                  clk,
    input  logic [AW-1:0]         bus_addr,
    input  logic [BUS_LANES-1:0]  bus_we,
    input  logic [BUS_DATA_W-1:0] bus_wdata,
    input  logic                  rd_en,
    output logic [BUS_DATA_W-1:0] rd_data,
    input  logic                  load_en,
    input  logic [AW-1:0]         load_addr,
    input  logic [BUS_DATA_W-1:0] load_data
);

    for (genvar lane = 0; lane < BUS_LANES; lane++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] q;

        // The load port is written after the bus port so it wins a same-word collision.
        always_ff @(posedge clk) begin
            if (bus_we[lane]) begin
                mem[bus_addr] <= bus_wdata[8*lane +: 8];
            end
            if (load_en) begin
                mem[load_addr] <= load_data[8*lane +: 8];
            end
            if (rd_en) begin
                q <= mem[bus_addr];
            end
        end

        assign rd_data[8*lane +: 8] = q;
    end

endmodule

// File: rtl/bus_ram_slave.sv
// Word-addressed RAM slave on a waitrequest-style bus, with configurable wait states,
// byte enables, a sticky error flag and a bench preload port.
module bus_ram_slave
    import bus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = BUS_BASE_ADDR,
    parameter int          WAIT_STATES = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    address,
    input  logic                           read,
    input  logic                           write,
    input  logic [31:0]                    writedata,
    input  logic [3:0]                     byteenable,
    output logic                           waitrequest,
    output logic [31:0]                    readdata,
    output logic                           err,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    bus_state_e    state, state_next;
    logic [3:0]    stall_cnt, stall_cnt_next;
    logic          request;
    logic          accept;
    logic          in_range;
    logic          rd_valid;
    logic          rd_en;
    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic [3:0]    bus_we;
    logic [31:0]   ram_q;

    assign request  = read | write;
    assign offset   = address - BASE_ADDR;
    assign word_idx = offset[AW+1:2];
    assign in_range = (address >= BASE_ADDR) && ((offset >> 2) < 32'(DEPTH_WORDS));

    // The pending cycle in IDLE already counts as the first wait state, so STALL exits
    // once the running total reaches WAIT_STATES (one wait state still visits STALL once).
    always_comb begin
        state_next     = state;
        stall_cnt_next = stall_cnt;
        waitrequest    = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (WAIT_STATES > 0) begin
                        waitrequest    = 1'b1;
                        state_next     = STALL;
                        stall_cnt_next = 4'd1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            STALL: begin
                waitrequest = 1'b1;
                if (!request) begin
                    state_next     = IDLE;
                    stall_cnt_next = 4'd0;
                end else if (({1'b0, stall_cnt} + 5'd1) >= 5'(WAIT_STATES)) begin
                    state_next     = DONE;
                    stall_cnt_next = 4'd0;
                end else begin
                    stall_cnt_next = stall_cnt + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next     = IDLE;
                stall_cnt_next = 4'd0;
            end
        endcase
        if (!reset) begin
            waitrequest = 1'b0;
        end
    end

    assign accept = reset & request & ~waitrequest;
    assign rd_en  = accept & read & ~write & in_range;
    assign bus_we = (accept && write && in_range) ? byteenable : 4'b0000;

    // An out-of-range read clears rd_valid so readdata reads back zero until the next good read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            stall_cnt <= 4'd0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            stall_cnt <= stall_cnt_next;
            if (accept) begin
                if (read && !write) begin
                    rd_valid <= in_range;
                end
                if (!in_range || (read && write)) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign readdata = rd_valid ? ram_q : 32'h0000_0000;

    byte_lane_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .bus_addr  (word_idx),
        .bus_we    (bus_we),
        .bus_wdata (writedata),
        .rd_en     (rd_en),
        .rd_data   (ram_q),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

endmodule

// File: tb/tb_bus_ram_slave.sv
// Scoreboard bench for bus_ram_slave: three instances (0, 3 and 4 wait states) share one
// reference memory model; a monitor per instance checks every accepted access.
module tb_bus_ram_slave;

    localparam int          N     = 3;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'hBFC00000;

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 4);
    endfunction

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [N];
    logic [31:0] addr    [N];
    logic        rd      [N];
    logic        wr      [N];
    logic [31:0] wdata   [N];
    logic [3:0]  be      [N];
    logic        wreq    [N];
    logic [31:0] rdata   [N];
    logic        err_o   [N];
    logic        ld_en   [N];
    logic [5:0]  ld_addr [N];
    logic [31:0] ld_data [N];

    resp_t       exp_q     [N][$];
    logic [31:0] model_mem [N][DEPTH];
    logic [31:0] model_rd  [N];
    logic        model_err [N];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        bit pend = 1'b0;

        bus_ram_slave #(
            .DEPTH_WORDS (DEPTH),
            .BASE_ADDR   (BASE),
            .WAIT_STATES (ws_of(g))
        ) dut (
            .clk         (clk),
            .reset       (rst_n[g]),
            .address     (addr[g]),
            .read        (rd[g]),
            .write       (wr[g]),
            .writedata   (wdata[g]),
            .byteenable  (be[g]),
            .waitrequest (wreq[g]),
            .readdata    (rdata[g]),
            .err         (err_o[g]),
            .load_en     (ld_en[g]),
            .load_addr   (ld_addr[g]),
            .load_data   (ld_data[g])
        );

        // An access seen accepted at one falling edge is checked at the next one.
        always @(negedge clk) begin
            resp_t e;
            if (pend) begin
                if (exp_q[g].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL dut%0d scoreboard: got an accepted access, expected none", g);
                end else begin
                    e = exp_q[g].pop_front();
                    checkOutput($sformatf("dut%0d readdata", g), rdata[g], e.rdata);
                    checkOutput($sformatf("dut%0d err", g), 32'(err_o[g]), 32'(e.err));
                end
            end
            pend = rst_n[g] && (rd[g] || wr[g]) && !wreq[g];
        end
    end

    // Reference behaviour: word index from plain byte-address arithmetic, sticky error.
    task automatic model_access(input int i, input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] b);
        bit oob;
        int idx;
        oob = (a < BASE) || (((a - BASE) / 32'd4) >= 32'(DEPTH));
        idx = oob ? 0 : int'((a - BASE) / 32'd4);
        if (w) begin
            if (!oob) begin
                for (int l = 0; l < 4; l++) begin
                    if (b[l]) model_mem[i][idx][8*l +: 8] = d[8*l +: 8];
                end
            end
            if (oob || r) model_err[i] = 1'b1;
        end else if (r) begin
            model_rd[i] = oob ? 32'h0 : model_mem[i][idx];
            if (oob) model_err[i] = 1'b1;
        end
        exp_q[i].push_back('{rdata: model_rd[i], err: model_err[i]});
    endtask

    // Issues one access, holds it until accepted and checks the number of wait cycles.
    task automatic applyStimulus(input int i, input logic r, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] b);
        int waits;
        waits    = 0;
        addr[i]  = a;
        rd[i]    = r;
        wr[i]    = w;
        wdata[i] = d;
        be[i]    = b;
        model_access(i, r, w, a, d, b);
        @(negedge clk);
        while (wreq[i] && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        checkOutput($sformatf("dut%0d wait cycles", i), 32'(waits), 32'(ws_of(i)));
        @(posedge clk);
        #1;
        rd[i] = 1'b0;
        wr[i] = 1'b0;
    endtask

    task automatic load_word(input int i, input int idx, input logic [31:0] d);
        ld_en[i]   = 1'b1;
        ld_addr[i] = 6'(idx);
        ld_data[i] = d;
        model_mem[i][idx] = d;
        @(posedge clk);
        #1;
        ld_en[i] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] old;
        logic [3:0]  b;
        logic        r;
        logic        w;
        int          kind;

        for (int i = 0; i < N; i++) begin
            rst_n[i]   = 1'b0;
            addr[i]    = 32'h0;
            rd[i]      = 1'b0;
            wr[i]      = 1'b0;
            wdata[i]   = 32'h0;
            be[i]      = 4'h0;
            ld_en[i]   = 1'b0;
            ld_addr[i] = 6'h0;
            ld_data[i] = 32'h0;
            model_rd[i]  = 32'h0;
            model_err[i] = 1'b0;
        end

        // Reset state, including a request held while reset is asserted.
        repeat (2) @(posedge clk);
        #1;
        addr[1] = BASE;
        rd[1]   = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("dut%0d reset waitrequest", i), 32'(wreq[i]), 32'h0);
            checkOutput($sformatf("dut%0d reset readdata", i), rdata[i], 32'h0);
            checkOutput($sformatf("dut%0d reset err", i), 32'(err_o[i]), 32'h0);
        end
        @(posedge clk);
        #1;
        rd[1] = 1'b0;
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;

        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < N; i++) begin
                ld_en[i]   = 1'b1;
                ld_addr[i] = 6'(k);
                ld_data[i] = $urandom;
                model_mem[i][k] = ld_data[i];
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < N; i++) ld_en[i] = 1'b0;

        load_word(0, 3, 32'h12345678);
        applyStimulus(0, 1'b1, 1'b0, 32'hBFC0000C, 32'h0, 4'h0);

        applyStimulus(1, 1'b0, 1'b1, 32'hBFC00004, 32'hDEADBEEF, 4'hF);
        applyStimulus(1, 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'h0);

        for (int i = 0; i < N; i++) begin
            load_word(i, 5, 32'hFFFFFFFF);
            applyStimulus(i, 1'b0, 1'b1, BASE + 32'd20, 32'h00000000, 4'b0101);
            applyStimulus(i, 1'b1, 1'b0, BASE + 32'd20, 32'h0, 4'h0);
            applyStimulus(i, 1'b0, 1'b1, BASE + 32'd20, 32'h13579BDF, 4'b0000);
            applyStimulus(i, 1'b1, 1'b0, BASE + 32'd20, 32'h0, 4'h0);
            applyStimulus(i, 1'b0, 1'b1, BASE + 32'd40, $urandom, 4'hF);
            applyStimulus(i, 1'b1, 1'b0, BASE + 32'd40, 32'h0, 4'h0);
            applyStimulus(i, 1'b1, 1'b0, BASE + 32'd252, 32'h0, 4'h0);
            applyStimulus(i, 1'b1, 1'b0, BASE + 32'd255, 32'h0, 4'h0);
        end

        // Same-edge load and bus write to word 9: the load value must survive.
        addr[0]    = BASE + 32'd36;
        wr[0]      = 1'b1;
        wdata[0]   = 32'hAAAA5555;
        be[0]      = 4'hF;
        ld_en[0]   = 1'b1;
        ld_addr[0] = 6'd9;
        ld_data[0] = 32'h0BADF00D;
        model_access(0, 1'b0, 1'b1, BASE + 32'd36, 32'hAAAA5555, 4'hF);
        model_mem[0][9] = 32'h0BADF00D;
        @(negedge clk);
        checkOutput("dut0 collision waitrequest", 32'(wreq[0]), 32'h0);
        @(posedge clk);
        #1;
        wr[0]    = 1'b0;
        ld_en[0] = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, BASE + 32'd36, 32'h0, 4'h0);

        // Read withdrawn on dut2 after two cycles in STALL.
        addr[2] = BASE + 32'd8;
        rd[2]   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("dut2 withdraw stalled", 32'(wreq[2]), 32'h1);
        @(posedge clk);
        #1;
        rd[2] = 1'b0;
        @(negedge clk);
        checkOutput("dut2 withdraw last stall", 32'(wreq[2]), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("dut2 withdraw waitrequest", 32'(wreq[2]), 32'h0);
        checkOutput("dut2 withdraw readdata", rdata[2], model_rd[2]);
        checkOutput("dut2 withdraw err", 32'(err_o[2]), 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(2, 1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'h0);

        // Reset asserted while a write on dut1 is stalled.
        old      = model_mem[1][7];
        addr[1]  = BASE + 32'd28;
        wr[1]    = 1'b1;
        wdata[1] = ~old;
        be[1]    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        checkOutput("dut1 stall before reset", 32'(wreq[1]), 32'h1);
        #1;
        rst_n[1] = 1'b0;
        #1;
        checkOutput("dut1 async reset waitrequest", 32'(wreq[1]), 32'h0);
        checkOutput("dut1 async reset err", 32'(err_o[1]), 32'h0);
        checkOutput("dut1 async reset readdata", rdata[1], 32'h0);
        model_rd[1]  = 32'h0;
        model_err[1] = 1'b0;
        wr[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        applyStimulus(1, 1'b1, 1'b0, BASE + 32'd28, 32'h0, 4'h0);

        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 120; k++) begin
                a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
                r = 1'($urandom_range(0, 1));
                d = $urandom;
                b = 4'($urandom_range(0, 15));
                applyStimulus(i, r, ~r, a, d, b);
            end
        end

        for (int i = 0; i < N; i++) begin
            applyStimulus(i, 1'b1, 1'b0, 32'h00000000, 32'h0, 4'h0);
            applyStimulus(i, 1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0);
            applyStimulus(i, 1'b0, 1'b1, BASE - 32'd4, 32'hFFFFFFFF, 4'hF);
            applyStimulus(i, 1'b1, 1'b0, BASE, 32'h0, 4'h0);
            applyStimulus(i, 1'b1, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 4'h0);
            applyStimulus(i, 1'b1, 1'b1, BASE + 32'd12, 32'hCAFEF00D, 4'hF);
            applyStimulus(i, 1'b1, 1'b0, BASE + 32'd12, 32'h0, 4'h0);
        end

        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 60; k++) begin
                kind = $urandom_range(0, 9);
                case (kind)
                    0:       a = 32'($urandom_range(0, 255));
                    1:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
                    2:       a = BASE - 32'(4 * $urandom_range(1, 8));
                    default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                endcase
                r = 1'($urandom_range(0, 1));
                w = ($urandom_range(0, 7) == 0) ? 1'b1 : ~r;
                applyStimulus(i, r, w, a, $urandom, 4'($urandom_range(0, 15)));
            end
        end

        @(negedge clk);
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("dut%0d scoreboard drained", i), 32'(exp_q[i].size()), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
